// File: rtl/alu_result_stage.sv
// ALU result stage: byte-merges each ALU result, queues it in a small FIFO for
// register-file writeback and maintains the architectural Z/N/C/V/E flags.
module alu_result_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int DEST_WIDTH = 4,
  parameter int DEPTH      = 2
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [DATA_WIDTH-1:0]    ResultIn,
  input  logic                     CarryIn,
  input  logic                     OverflowIn,
  input  logic                     EqualIn,
  input  logic [DATA_WIDTH-1:0]    OldIn,
  input  logic [1:0]               ByteMode,
  input  logic [DEST_WIDTH-1:0]    DestIn,
  input  logic                     WriteFlags,
  input  logic                     Flush,
  output logic                     WbValid,
  input  logic                     WbReady,
  output logic [DATA_WIDTH-1:0]    WbData,
  output logic [DEST_WIDTH-1:0]    WbDest,
  output logic                     FlagZ,
  output logic                     FlagN,
  output logic                     FlagC,
  output logic                     FlagV,
  output logic                     FlagE,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int HALF = DATA_WIDTH / 2;

  logic [CW-1:0]         r_wrPtr;
  logic [CW-1:0]         r_rdPtr;
  logic [DATA_WIDTH-1:0] r_memData [DEPTH];
  logic [DEST_WIDTH-1:0] r_memDest [DEPTH];
  logic                  r_flagZ;
  logic                  r_flagN;
  logic                  r_flagC;
  logic                  r_flagV;
  logic                  r_flagE;

  logic [CW-1:0]         w_count;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [AW-1:0]         w_wrIdx;
  logic [AW-1:0]         w_rdIdx;
  logic [DATA_WIDTH-1:0] w_merged;

  // Pointers carry one extra wrap bit so full and empty differ when indices match.
  assign w_count = r_wrPtr - r_rdPtr;
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (w_count == CW'(DEPTH));
  assign w_wrIdx = r_wrPtr[AW-1:0];
  assign w_rdIdx = r_rdPtr[AW-1:0];

  // InReady looks only at occupancy, so a pop never frees a slot on the same edge.
  assign w_push = InValid & ~w_full & ~Flush;
  assign w_pop  = ~w_empty & WbReady & ~Flush;

  always_comb begin
    w_merged = ResultIn;
    case (ByteMode)
      2'b01:   w_merged = {OldIn[DATA_WIDTH-1:HALF], ResultIn[HALF-1:0]};
      2'b10:   w_merged = {ResultIn[DATA_WIDTH-1:HALF], OldIn[HALF-1:0]};
      default: w_merged = ResultIn;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (Flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + CW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + CW'(1);
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_memData[i] <= '0;
        r_memDest[i] <= '0;
      end
    end else if (w_push) begin
      r_memData[w_wrIdx] <= w_merged;
      r_memDest[w_wrIdx] <= DestIn;
    end
  end

  // Flags are taken from the merged value at accept time, so they follow issue order.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_flagZ <= 1'b0;
      r_flagN <= 1'b0;
      r_flagC <= 1'b0;
      r_flagV <= 1'b0;
      r_flagE <= 1'b0;
    end else if (w_push && WriteFlags) begin
      r_flagZ <= (w_merged == '0);
      r_flagN <= w_merged[DATA_WIDTH-1];
      r_flagC <= CarryIn;
      r_flagV <= OverflowIn;
      r_flagE <= EqualIn;
    end
  end

  assign InReady = ~w_full;
  assign WbValid = ~w_empty;
  assign WbData  = w_empty ? '0 : r_memData[w_rdIdx];
  assign WbDest  = w_empty ? '0 : r_memDest[w_rdIdx];
  assign Count   = w_count;
  assign FlagZ   = r_flagZ;
  assign FlagN   = r_flagN;
  assign FlagC   = r_flagC;
  assign FlagV   = r_flagV;
  assign FlagE   = r_flagE;

endmodule

// File: tb/tb_alu_result_stage.sv
// Testbench for alu_result_stage: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model.
module tb_alu_result_stage;

  localparam int DW    = 16;
  localparam int DEST  = 4;
  localparam int DEPTH = 2;

  logic            Clock = 1'b0;
  logic            Reset;
  logic            InValid;
  logic            InReady;
  logic [DW-1:0]   ResultIn;
  logic            CarryIn;
  logic            OverflowIn;
  logic            EqualIn;
  logic [DW-1:0]   OldIn;
  logic [1:0]      ByteMode;
  logic [DEST-1:0] DestIn;
  logic            WriteFlags;
  logic            Flush;
  logic            WbValid;
  logic            WbReady;
  logic [DW-1:0]   WbData;
  logic [DEST-1:0] WbDest;
  logic            FlagZ, FlagN, FlagC, FlagV, FlagE;
  logic [$clog2(DEPTH):0] Count;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 1'b0;

  alu_result_stage #(.DATA_WIDTH(DW), .DEST_WIDTH(DEST), .DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .ResultIn(ResultIn), .CarryIn(CarryIn), .OverflowIn(OverflowIn),
    .EqualIn(EqualIn), .OldIn(OldIn), .ByteMode(ByteMode), .DestIn(DestIn),
    .WriteFlags(WriteFlags), .Flush(Flush), .WbValid(WbValid),
    .WbReady(WbReady), .WbData(WbData), .WbDest(WbDest),
    .FlagZ(FlagZ), .FlagN(FlagN), .FlagC(FlagC), .FlagV(FlagV),
    .FlagE(FlagE), .Count(Count)
  );

  always #5 Clock = ~Clock;

  // Reference model: a queue of accepted entries plus the five flag bits.
  typedef struct {
    logic [DW-1:0]   data;
    logic [DEST-1:0] dest;
  } entry_t;

  entry_t mQ[$];
  logic mZ = 1'b0, mN = 1'b0, mC = 1'b0, mV = 1'b0, mE = 1'b0;

  function automatic logic [DW-1:0] mergeRef(input logic [1:0] mode,
                                             input logic [DW-1:0] res,
                                             input logic [DW-1:0] old);
    case (mode)
      2'b01:   return (old & 16'hFF00) | (res & 16'h00FF);
      2'b10:   return (res & 16'hFF00) | (old & 16'h00FF);
      default: return res;
    endcase
  endfunction

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mQ.delete();
      mZ = 1'b0; mN = 1'b0; mC = 1'b0; mV = 1'b0; mE = 1'b0;
    end else begin
      automatic bit doPush = InValid && (mQ.size() < DEPTH) && !Flush;
      automatic bit doPop  = (mQ.size() > 0) && WbReady && !Flush;
      automatic logic [DW-1:0] m = mergeRef(ByteMode, ResultIn, OldIn);
      if (Flush) begin
        mQ.delete();
      end else begin
        if (doPop) void'(mQ.pop_front());
        if (doPush) begin
          mQ.push_back('{data: m, dest: DestIn});
          if (WriteFlags) begin
            mZ = (m == 16'd0);
            mN = (m >= 16'h8000);
            mC = CarryIn;
            mV = OverflowIn;
            mE = EqualIn;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle outside reset, all outputs must match the model.
  always @(negedge Clock) begin
    if (checkEn && Reset === 1'b0) begin
      automatic int sz = mQ.size();
      checkOutput("model.WbValid", 32'(WbValid), 32'(sz != 0));
      checkOutput("model.InReady", 32'(InReady), 32'(sz < DEPTH));
      checkOutput("model.Count",   32'(Count),   32'(sz));
      checkOutput("model.WbData",  32'(WbData),  sz != 0 ? 32'(mQ[0].data) : 32'd0);
      checkOutput("model.WbDest",  32'(WbDest),  sz != 0 ? 32'(mQ[0].dest) : 32'd0);
      checkOutput("model.Flags",
                  32'({FlagZ, FlagN, FlagC, FlagV, FlagE}),
                  32'({mZ, mN, mC, mV, mE}));
    end
  end

  task automatic applyStimulus(input logic v, input logic [DW-1:0] res,
                               input logic c, input logic o, input logic e,
                               input logic [DW-1:0] old, input logic [1:0] mode,
                               input logic [DEST-1:0] dest, input logic wf,
                               input logic fl, input logic rdy);
    InValid    = v;
    ResultIn   = res;
    CarryIn    = c;
    OverflowIn = o;
    EqualIn    = e;
    OldIn      = old;
    ByteMode   = mode;
    DestIn     = dest;
    WriteFlags = wf;
    Flush      = fl;
    WbReady    = rdy;
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(0, 16'h0, 0, 0, 0, 16'h0, 2'b00, 4'h0, 0, 0, rdy);
  endtask

  task automatic pushSimple(input logic [DW-1:0] res, input logic wf, input logic rdy);
    applyStimulus(1, res, 0, 0, 0, 16'h0, 2'b00, 4'h5, wf, 0, rdy);
  endtask

  initial begin
    idle(0);
    Reset = 1'b0;
    #1 Reset = 1'b1;
    #1;
    checkOutput("reset.Count",   32'(Count),   32'd0);
    checkOutput("reset.WbValid", 32'(WbValid), 32'd0);
    checkOutput("reset.InReady", 32'(InReady), 32'd1);
    checkOutput("reset.WbData",  32'(WbData),  32'd0);
    checkOutput("reset.WbDest",  32'(WbDest),  32'd0);
    checkOutput("reset.Flags",   32'({FlagZ, FlagN, FlagC, FlagV, FlagE}), 32'd0);
    @(negedge Clock);
    Reset   = 1'b0;
    checkEn = 1'b1;

    // Zero result with carry: Z and C set, popped on the following edge.
    applyStimulus(1, 16'h0000, 1, 0, 0, 16'h0, 2'b00, 4'h3, 1, 0, 1);
    @(negedge Clock);
    checkOutput("t1.WbValid", 32'(WbValid), 32'd1);
    checkOutput("t1.WbData",  32'(WbData),  32'h0000);
    checkOutput("t1.WbDest",  32'(WbDest),  32'h3);
    checkOutput("t1.ZNC",     32'({FlagZ, FlagN, FlagC}), 32'b101);
    idle(1);
    @(negedge Clock);
    checkOutput("t1.CountAfterPop", 32'(Count), 32'd0);

    // Byte merges.
    applyStimulus(1, 16'h12AB, 0, 0, 0, 16'hCD00, 2'b01, 4'h1, 0, 0, 0);
    @(negedge Clock);
    checkOutput("t2.SetL", 32'(WbData), 32'hCDAB);
    applyStimulus(1, 16'h1234, 0, 0, 0, 16'h00EF, 2'b10, 4'h2, 1, 0, 1);
    @(negedge Clock);
    checkOutput("t2.SetH", 32'(WbData), 32'h12EF);
    checkOutput("t2.N",    32'(FlagN),  32'd0);
    idle(1);
    @(negedge Clock);

    // Fill, overflow attempt, drain in order.
    pushSimple(16'h1111, 0, 0);
    @(negedge Clock);
    pushSimple(16'h2222, 0, 0);
    @(negedge Clock);
    checkOutput("t3.CountFull", 32'(Count),   32'd2);
    checkOutput("t3.InReady",   32'(InReady), 32'd0);
    pushSimple(16'h3333, 0, 0);
    @(negedge Clock);
    checkOutput("t3.CountHold", 32'(Count),  32'd2);
    checkOutput("t3.HeadHold",  32'(WbData), 32'h1111);
    idle(1);
    @(negedge Clock);
    checkOutput("t3.Second", 32'(WbData), 32'h2222);
    @(negedge Clock);
    checkOutput("t3.Drained", 32'(WbValid), 32'd0);

    // Steady push+pop at Count=1 across pointer wraps.
    pushSimple(16'h0100, 0, 0);
    @(negedge Clock);
    for (int i = 0; i < 10; i++) begin
      pushSimple(16'(16'h0101 + i), 0, 1);
      @(negedge Clock);
      checkOutput("t4.Count", 32'(Count),  32'd1);
      checkOutput("t4.Order", 32'(WbData), 32'(16'h0101 + i));
    end
    idle(1);
    @(negedge Clock);

    // Flush discards queued entries and the coincident push; flags hold.
    applyStimulus(1, 16'hF00F, 1, 1, 1, 16'h0, 2'b00, 4'h7, 1, 0, 0);
    @(negedge Clock);
    pushSimple(16'h0002, 0, 0);
    @(negedge Clock);
    checkOutput("t5.CountFull", 32'(Count), 32'd2);
    applyStimulus(1, 16'h0000, 0, 0, 0, 16'h0, 2'b00, 4'h0, 1, 1, 1);
    @(negedge Clock);
    checkOutput("t5.Count",   32'(Count),   32'd0);
    checkOutput("t5.WbValid", 32'(WbValid), 32'd0);
    checkOutput("t5.Flags",   32'({FlagZ, FlagN, FlagC, FlagV, FlagE}), 32'b01111);
    pushSimple(16'h0005, 0, 0);
    @(negedge Clock);
    applyStimulus(1, 16'h0000, 0, 0, 0, 16'h0, 2'b00, 4'h0, 1, 1, 1);
    @(negedge Clock);
    checkOutput("t5.CountOne", 32'(Count), 32'd0);
    checkOutput("t5.ZHeld",    32'(FlagZ), 32'd0);

    // Flag persistence, then asynchronous reset mid-cycle.
    pushSimple(16'h8000, 1, 1);
    @(negedge Clock);
    pushSimple(16'h0001, 0, 1);
    @(negedge Clock);
    checkOutput("t6.NZ",    32'({FlagN, FlagZ}), 32'b10);
    checkOutput("t6.Count", 32'(Count), 32'd1);
    idle(0);
    #2 Reset = 1'b1;
    #1;
    checkOutput("t6.AsyncCount", 32'(Count),   32'd0);
    checkOutput("t6.AsyncValid", 32'(WbValid), 32'd0);
    checkOutput("t6.AsyncFlags", 32'({FlagZ, FlagN, FlagC, FlagV, FlagE}), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom),
                    16'($urandom), 2'($urandom), 4'($urandom),
                    1'($urandom), $urandom_range(0, 24) == 0,
                    $urandom_range(0, 2) != 0);
      @(negedge Clock);
    end
    idle(1);
    repeat (4) @(negedge Clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Sits directly downstream of the 16-bit ALU. Captures each ALU result together with its carry, overflow and equal bits into a small FIFO, then presents it to register-file writeback over a valid/ready handshake.
- Merges byte-wide results from SetL/SetH with the destination's old value.
- Holds the architectural status-flag register: Z, N, C, V and E.

Parameters:
- DATA_WIDTH, 16, width of result, old-value and writeback data.
- DEST_WIDTH, 4, register-file destination index width.
- DEPTH, 2, FIFO entries; legal values 2 or 4; pointers use log2(DEPTH) bits plus one wrap bit.

Ports:
- Clock  input  1  rising-edge clock; the only clock.
- Reset  input  1  asynchronous, active-high reset.
- InValid  input  1  ALU result on the inputs is valid.
- InReady  output  1  stage can accept an entry; high iff Count < DEPTH.
- ResultIn  input  DATA_WIDTH  ALU result.
- CarryIn  input  1  ALU carry/borrow.
- OverflowIn  input  1  ALU overflow.
- EqualIn  input  1  ALU IsEqual result.
- OldIn  input  DATA_WIDTH  current destination register value, used for byte merge.
- ByteMode  input  2  merge mode: 00 full, 01 low byte (SetL), 10 high byte (SetH), 11 full.
- DestIn  input  DEST_WIDTH  destination register index.
- WriteFlags  input  1  update the flag register on accept.
- Flush  input  1  synchronous FIFO discard.
- WbValid  output  1  head entry is valid.
- WbReady  input  1  register file accepts the head entry.
- WbData  output  DATA_WIDTH  merged data of the head entry.
- WbDest  output  DEST_WIDTH  destination index of the head entry.
- FlagZ, FlagN, FlagC, FlagV, FlagE  output  1 each  status flags.
- Count  output  log2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset asserted, at any time and mid-traffic:
  - FIFO pointers and Count go to 0; WbValid=0; InReady=1.
  - All flags go to 0.
  - WbData and WbDest read 0 while the FIFO is empty.
- Push occurs on a rising edge when InValid & InReady & ~Flush.
- Merge is combinational at the input and is stored as data:
  - ByteMode 01: {OldIn[15:8], ResultIn[7:0]}.
  - ByteMode 10: {ResultIn[15:8], OldIn[7:0]}.
  - ByteMode 00 or 11: ResultIn.
- Flags update on the push edge only when WriteFlags=1:
  - Z = (merged == 0); N = merged[MSB].
  - C = CarryIn; V = OverflowIn; E = EqualIn.
  - Flags therefore follow issue order and are visible the cycle after accept.
- When WriteFlags=0, or no push occurs, all flags hold.
- Pop occurs on a rising edge when WbValid & WbReady & ~Flush.
- WbData and WbDest are driven from the head entry. They must stay stable while WbValid=1 and WbReady=0.
- Latency: an entry pushed at edge k is presented with WbValid=1 after edge k. There is no input-to-output combinational path.
- InReady depends only on Count, never on WbReady.
  - When full, no push occurs even if a pop happens on the same edge.
  - InReady rises the cycle after the pop.
- Simultaneous push and pop, with 0 < Count < DEPTH: both happen and Count is unchanged.
- Empty: WbValid=0, and WbReady is ignored.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Full and empty are distinguished by the wrap bit.
- Flush=1 on an edge:
  - Count=0, pointers equal, WbValid=0 the next cycle.
  - Any push or pop presented on that edge is discarded.
  - Flags hold.
- InValid=1 while InReady=0: the input is ignored. The upstream side must hold its data.
- The bench checks for X on any output after Reset.

Test Plan:
- Reset then push ResultIn=0x0000, CarryIn=1, WriteFlags=1, WbReady=1 -> the next cycle WbValid=1, WbData=0x0000, Z=1, N=0, C=1; after the pop, Count=0.
- ByteMode=01, ResultIn=0x12AB, OldIn=0xCD00 -> WbData=0xCDAB. ByteMode=10, ResultIn=0x1234, OldIn=0x00EF -> WbData=0x12EF. For ByteMode=10 with WriteFlags=1, N=0.
- WbReady=0, push 0x1111 then 0x2222 (DEPTH=2) -> Count=2, InReady=0. A third push of 0x3333 is ignored and WbData holds 0x1111. Then WbReady=1 -> 0x1111 then 0x2222 are popped.
- Count=1 with simultaneous push and pop, repeated for 10 cycles with incrementing data -> Count stays 1, output order matches input, pointers wrap cleanly.
- Two pushes, then Flush=1 with InValid=1 -> Count=0, WbValid=0, the pushed entry is discarded, flags unchanged.
- Push 0x8000 with WriteFlags=1, then 0x0001 with WriteFlags=0 -> N=1 and Z=0 persist. Assert Reset mid-stream -> Count=0 and all flags 0 immediately, without waiting for a clock edge.
